// File: rtl/alu_multicycle.sv
// alu_multicycle: registered execute-stage ALU with single-cycle logic/arith ops
// and iterative unsigned multiply / restoring divide behind start/busy/done.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one MUL/DIVU iteration per clock, iteration counter counts down
// DONE  | done=1 for one cycle; a new start may be accepted here
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] hi, lo;
  logic             is_mul;

  logic             is_multi;
  logic             accept, load_multi, load_single, finish;

  logic [WIDTH-1:0] single_out;
  logic             single_ovf;
  logic [WIDTH-1:0] sum, diff;

  logic [WIDTH:0]   mul_add;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign is_multi = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; RUN ends on the iteration that takes the counter to 0
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = is_multi ? S_RUN : S_DONE;
        else       state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs and datapath load strobes decoded from state
  always_comb begin
    busy        = (state == S_RUN);
    done        = (state == S_DONE);
    accept      = start && (state != S_RUN);
    load_multi  = accept && is_multi;
    load_single = accept && !is_multi;
    finish      = (state == S_RUN) && (cnt == CNT_W'(1));
  end

  // Single-cycle result straight from the live operands at acceptance
  always_comb begin
    sum        = A + B;
    diff       = A + ~B + WIDTH'(1);
    single_out = '0;
    single_ovf = 1'b0;
    case (ALUControl)
      OP_AND:  single_out = A & B;
      OP_OR:   single_out = A | B;
      OP_ADD: begin
        single_out = sum;
        single_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        single_out = diff;
        single_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  single_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: single_out = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_NOR:  single_out = ~(A | B);
      OP_NAND: single_out = ~(A & B);
      default: single_out = '0;
    endcase
  end

  // One iteration: MUL shifts {hi,lo} right after a conditional add, DIVU
  // shifts the dividend into hi and restores when the trial subtract fails.
  // With B==0 every trial succeeds, leaving quotient all ones and hi = A.
  always_comb begin
    mul_add   = {1'b0, hi} + (lo[0] ? {1'b0, a_reg} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_sub   = div_shift[WIDTH-1:0] - b_reg;
    if (is_mul) begin
      step_hi = mul_add[WIDTH:1];
      step_lo = {mul_add[0], lo[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], div_ge};
    end
  end

  // Iteration registers and result registers; results change only on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      hi       <= '0;
      lo       <= '0;
      is_mul   <= 1'b0;
      ALUOut   <= '0;
      ResultHi <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      if (load_multi) begin
        a_reg  <= A;
        b_reg  <= B;
        is_mul <= (ALUControl == OP_MUL);
        hi     <= '0;
        lo     <= (ALUControl == OP_MUL) ? B : A;
        cnt    <= CNT_W'(WIDTH);
      end else if (busy) begin
        hi  <= step_hi;
        lo  <= step_lo;
        cnt <= cnt - CNT_W'(1);
      end

      if (load_single) begin
        ALUOut   <= single_out;
        ResultHi <= '0;
        Zero     <= (single_out == '0);
        Overflow <= single_ovf;
        DivZero  <= 1'b0;
      end else if (finish) begin
        ALUOut   <= step_lo;
        ResultHi <= step_hi;
        Zero     <= (step_lo == '0);
        Overflow <= 1'b0;
        DivZero  <= !is_mul && (b_reg == '0);
      end
    end
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the 16-bit combinational datapath ALU. It adds signed/unsigned compare, an overflow flag, and iterative unsigned multiply and divide behind a start/busy/done handshake. It sits in the execute stage: control issues one operation, and the datapath waits on `done` before writeback. Single-cycle operations complete in one clock; MUL and DIVU complete in WIDTH+1 clocks.

## Interface
- `WIDTH`, default 16: operand/result width in bits. Legal range is WIDTH ≥ 4.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled on a rising edge only while `busy`=0.
- `A`  in  WIDTH  operand A; captured when start is accepted.
- `B`  in  WIDTH  operand B; captured when start is accepted.
- `ALUControl`  in  4  operation code; captured when start is accepted.
- `ALUOut`  out  WIDTH  result low word (registered).
- `ResultHi`  out  WIDTH  MUL: product high word; DIVU: remainder; all other ops: 0.
- `Zero`  out  1  `ALUOut`==0 (registered with `ALUOut`).
- `Overflow`  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- `DivZero`  out  1  DIVU with B==0; 0 for all other ops.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.

## Operation
- Encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A + ~B + 1)
  - 0111 SLT, signed; result 1 or 0
  - 1000 SLTU, unsigned
  - 1100 NOR
  - 1101 NAND
  - 0011 MUL, unsigned, 2·WIDTH-bit product
  - 0100 DIVU, unsigned
  - Any other code: ALUOut=0, Zero=1, all other flags 0; completes as a single-cycle op.
- Arithmetic is modulo 2^WIDTH. Overflow for ADD = sign(A)==sign(B) && sign(sum)!=sign(A). Overflow for SUB = sign(A)!=sign(B) && sign(diff)!=sign(A).
- States:
  - IDLE: accept start. Single-cycle code → DONE. MUL/DIVU → RUN, with iteration counter = WIDTH.
  - RUN: one shift-add (MUL) or restoring shift-subtract (DIVU) step per cycle; counter decrements. When the counter reaches 0 → DONE.
  - DONE: `done`=1 for exactly one cycle. Accept start (same rules as IDLE), otherwise → IDLE.
- MUL: {ResultHi, ALUOut} = A×B.
- DIVU: ALUOut = A/B, ResultHi = A%B.
- DIVU with B==0: ALUOut = all ones, ResultHi = A, DivZero=1. Full WIDTH+1 latency is still taken.
- Outputs hold their last values until the next completion; they never change while in RUN.
- Operands and code are captured at acceptance. Input changes during RUN have no effect.
- start while busy=1 is ignored; it is not queued.

## Timing
- Reset: all outputs are 0 (`ALUOut`, `ResultHi`, `Zero`, `Overflow`, `DivZero`, `busy`, `done`). State = IDLE, counter = 0.
- Start accepted at edge k, single-cycle op: results and `done`=1 are visible after edge k+1. `busy` stays 0.
- Start accepted at edge k, MUL/DIVU: `busy`=1 after edges k+1 … k+WIDTH. Results and `done`=1 after edge k+WIDTH+1, with `busy`=0 in that cycle.
- Back-to-back: start held high in the DONE cycle is accepted. Single-cycle ops therefore sustain one result per clock, with `done` held high continuously.
- reset asserted mid-RUN: the operation is aborted, all outputs return to reset values on that edge, and no `done` pulse is produced.
- reset and start in the same cycle: reset wins and start is dropped.

## Test plan
- WIDTH=16, ADD A=0x7FFF B=0x0001 → one cycle later: ALUOut=0x8000, Overflow=1, Zero=0, done=1, busy never high.
- SUB A=0x0005 B=0x0005 → ALUOut=0, Zero=1, Overflow=0. Then SLT A=0xFFFF B=0x0001 → ALUOut=1; SLTU with the same operands → ALUOut=0; both issued back-to-back, done high on consecutive cycles.
- MUL A=0x1234 B=0x0100 → busy high for exactly 16 cycles, done on cycle 17: ALUOut=0x3400, ResultHi=0x0012. A second start during busy (A=1, B=1) is ignored, and results are unchanged.
- DIVU A=100 B=7 → done on cycle 17: ALUOut=14, ResultHi=2, DivZero=0. DIVU A=0x00AB B=0 → ALUOut=0xFFFF, ResultHi=0x00AB, DivZero=1.
- MUL started, reset pulsed on cycle 8 → all outputs 0, no done. A new ADD 3+4 then returns ALUOut=7 one cycle later.
- WIDTH=8 build: MUL 0xFF×0xFF → done on cycle 9: ALUOut=0x01, ResultHi=0xFE. Unsupported code 1111 → ALUOut=0, Zero=1, done after 1 cycle.
